// File: rtl/bram_tile_loader.sv
// Tile loader: writes one tile of 32-bit stream words into BRAM Port A, then hands off to the fetch stage.
// Optional LOAD_CHECKSUM_EN adds tile_checksum, the XOR of every committed write in the tile.
module bram_tile_loader #(
   parameter int DATA_WIDTH         = 32,
   parameter int ADDR_WIDTH         = 14,
   parameter int WORDS_PER_TILE     = 4096,
   parameter int WRITE_START_OFFSET = 896,
   parameter int PACK_RATIO         = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_load,
   input  logic                  abort,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   input  logic                  fetch_idle,
   output logic                  ena,
   output logic                  wea,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [DATA_WIDTH-1:0] dina,
   output logic                  load_busy,
   output logic                  load_done,
   output logic                  start_fetch,
   output logic [ADDR_WIDTH:0]   words_written,
   output logic [ADDR_WIDTH:0]   fetch_words
`ifdef LOAD_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] tile_checksum
`endif
);

   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(WORDS_PER_TILE - 1);
   localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(WRITE_START_OFFSET);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_HANDOFF
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      beat_q, beat_d;
   logic [CNT_W-1:0]      words_q, words_d;
   logic                  wea_q, wea_d;
   logic [ADDR_WIDTH-1:0] addra_q, addra_d;
   logic [DATA_WIDTH-1:0] dina_q, dina_d;
   logic                  done_q, done_d;
`ifdef LOAD_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] cksum_q, cksum_d;
`endif

   // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      words_d     = words_q;
      wea_d       = 1'b0;
      addra_d     = addra_q;
      dina_d      = dina_q;
      done_d      = 1'b0;
      s_ready     = 1'b0;
      start_fetch = 1'b0;
`ifdef LOAD_CHECKSUM_EN
      cksum_d     = cksum_q;
`endif

      if (abort && (state_q != ST_IDLE)) begin
         // Cancel wins over everything except reset; nothing is accepted and no handoff occurs.
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_load) begin
                  state_d = ST_LOAD;
                  beat_d  = '0;
                  words_d = '0;
`ifdef LOAD_CHECKSUM_EN
                  cksum_d = '0;
`endif
               end
            end

            ST_LOAD: begin
               s_ready = 1'b1;
               if (s_valid) begin
                  wea_d   = 1'b1;
                  // Address wraps naturally through truncation to ADDR_WIDTH bits.
                  addra_d = START_ADDR + beat_q[ADDR_WIDTH-1:0];
                  dina_d  = s_data;
                  beat_d  = beat_q + 1'b1;
                  words_d = words_q + 1'b1;
`ifdef LOAD_CHECKSUM_EN
                  cksum_d = cksum_q ^ s_data;
`endif
                  if (beat_q == LAST_BEAT) begin
                     state_d = ST_DRAIN;
                  end
               end
            end

            ST_DRAIN: begin
               done_d  = 1'b1;
               state_d = ST_HANDOFF;
            end

            ST_HANDOFF: begin
               if (fetch_idle) begin
                  start_fetch = 1'b1;
                  state_d     = ST_IDLE;
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         words_q <= '0;
         wea_q   <= 1'b0;
         addra_q <= START_ADDR;
         dina_q  <= '0;
         done_q  <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
         cksum_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         words_q <= words_d;
         wea_q   <= wea_d;
         addra_q <= addra_d;
         dina_q  <= dina_d;
         done_q  <= done_d;
`ifdef LOAD_CHECKSUM_EN
         cksum_q <= cksum_d;
`endif
      end
   end

   assign ena           = 1'b1;
   assign wea           = wea_q;
   assign addra         = addra_q;
   assign dina          = dina_q;
   assign load_busy     = (state_q != ST_IDLE);
   assign load_done     = done_q;
   assign words_written = words_q;
   assign fetch_words   = CNT_W'(WORDS_PER_TILE / PACK_RATIO);
`ifdef LOAD_CHECKSUM_EN
   assign tile_checksum = cksum_q;
`endif

endmodule

// File: doc/bram_tile_loader.md
Name: bram_tile_loader

Overview:
- Upstream stage of the fetch/BRAM path. Accepts a 32-bit valid/ready word stream and writes one tile of WORDS_PER_TILE words into the BRAM's 32-bit write port (Port A), starting at WRITE_START_OFFSET.
- When the tile is fully committed, it hands off to the 256-bit fetch stage with a single start_fetch pulse.
- The fetch stage reads the same tile as WORDS_PER_TILE/PACK_RATIO 256-bit words.

Parameters:
- DATA_WIDTH, 32, write-port word width.
- ADDR_WIDTH, 14, write-port address width (16384 x 32b).
- WORDS_PER_TILE, 4096, 32-bit words per tile; must be >= 1 and a multiple of PACK_RATIO.
- WRITE_START_OFFSET, 896, first write address; equals fetch-side offset 112 x PACK_RATIO.
- PACK_RATIO, 8, write words per read word; used only for the fetch_words output.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start_load  in  1  one-cycle pulse; arms loading of one tile.
- abort  in  1  synchronous cancel of the current load.
- s_valid  in  1  input word valid.
- s_data  in  DATA_WIDTH  input word.
- s_ready  out  1  loader can accept a word this cycle.
- fetch_idle  in  1  high when the fetch stage can take start_fetch.
- ena  out  1  BRAM Port A enable.
- wea  out  1  BRAM Port A write enable.
- addra  out  ADDR_WIDTH  BRAM Port A address.
- dina  out  DATA_WIDTH  BRAM Port A write data.
- load_busy  out  1  high in LOAD, DRAIN and HANDOFF.
- load_done  out  1  one-cycle pulse when the final write is committed.
- start_fetch  out  1  one-cycle pulse to the fetch stage.
- words_written  out  ADDR_WIDTH+1  count of committed writes in the current tile.
- fetch_words  out  ADDR_WIDTH+1  constant, WORDS_PER_TILE/PACK_RATIO.

Behaviour:
- Reset values: s_ready, wea, load_done, start_fetch, load_busy = 0; ena = 1; addra = WRITE_START_OFFSET; dina = 0; words_written = 0. State = IDLE.
- FSM states: IDLE, LOAD, DRAIN, HANDOFF.
- IDLE:
  - start_load -> LOAD; beat counter and words_written clear to 0.
  - start_load is ignored in every other state.
- LOAD:
  - s_ready = 1 combinationally whenever state is LOAD.
  - A beat is accepted when s_valid && s_ready.
  - Each accepted beat registers wea=1, addra=(WRITE_START_OFFSET+beat_idx) mod 2^ADDR_WIDTH, and dina=s_data on the next edge. Write latency is exactly 1 cycle.
  - wea = 0 in any cycle that follows a non-accepted cycle; addra and dina hold their last values.
  - Acceptance of beat WORDS_PER_TILE-1 -> DRAIN; s_ready drops the following cycle.
- DRAIN (1 cycle):
  - The final write is on the port (wea=1).
  - words_written increments on every wea cycle and reaches WORDS_PER_TILE here.
  - Next cycle: load_done=1 for one cycle, state -> HANDOFF.
- HANDOFF:
  - Waits for fetch_idle.
  - In the first cycle with fetch_idle=1, start_fetch=1 for one cycle and state -> IDLE.
  - If fetch_idle is already 1 when entering HANDOFF, start_fetch coincides with load_done.
- Address wrap: addresses wrap modulo 2^ADDR_WIDTH silently, with no error.
- Abort:
  - In LOAD, DRAIN or HANDOFF -> IDLE next cycle.
  - wea is forced 0 that cycle; a pending write is dropped.
  - No load_done and no start_fetch; words_written holds its last value.
  - abort in IDLE has no effect.
- Priority: rst > abort > start_load/stream.
- An s_valid beat in the same cycle as abort is not accepted (s_ready=0 when abort=1).
- rst mid-load returns to the reset values above on the next edge.

Optional Feature:
- Macro: LOAD_CHECKSUM_EN.
- When defined, adds output tile_checksum [DATA_WIDTH-1:0]:
  - XOR of all committed dina values in the tile.
  - Cleared on start_load accept and on rst.
  - Valid and stable from the load_done cycle until the next start_load.
- When undefined: no port and no logic.

Test Plan:
- Full tile: rst, start_load, stream data=i*2+2 for i=0..4095 with s_valid held high. Expect first write addra=896/dina=2, last write addra=4991/dina=8192, 4096 consecutive wea cycles, load_done 2 cycles after last accept, words_written=4096, start_fetch with fetch_idle=1.
- Backpressure gaps: s_valid toggled 1/0 every cycle over a 16-word tile (WORDS_PER_TILE=16). Expect wea only in the cycle after each accept; addra 896..911 with no skips or duplicates.
- Wrap: WRITE_START_OFFSET=16380, WORDS_PER_TILE=8. Expect addra sequence 16380,16381,16382,16383,0,1,2,3.
- Handoff stall: fetch_idle=0 for 20 cycles after load_done. Expect load_busy=1 throughout, start_fetch=0; start_fetch pulses exactly once in the cycle fetch_idle rises.
- Abort: abort after 100 accepts. Expect IDLE next cycle, wea=0, no load_done, no start_fetch, words_written=100. A following start_load restarts at addra=896.
- Checksum (LOAD_CHECKSUM_EN): 8-word tile of 1..8. Expect tile_checksum=0x00000008 at load_done.
